// File: rtl/mem_seq_pkg.sv
// Shared opcode constants, FSM states, access sizes and opcode decode
// for the byte-serial memory sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef struct packed {
        logic  valid;
        logic  load;
        logic  uns;
        size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [5:0] opc);
        op_info_t r;
        r.valid = 1'b1;
        r.load  = 1'b1;
        r.uns   = 1'b0;
        r.size  = BYTE;
        case (opc)
            OP_LB:  r.size = BYTE;
            OP_LH:  r.size = HALF;
            OP_LW:  r.size = WORD;
            OP_LBU: begin r.size = BYTE; r.uns = 1'b1; end
            OP_LHU: begin r.size = HALF; r.uns = 1'b1; end
            OP_SB:  begin r.size = BYTE; r.load = 1'b0; end
            OP_SH:  begin r.size = HALF; r.load = 1'b0; end
            OP_SW:  begin r.size = WORD; r.load = 1'b0; end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Index of the final byte (N-1) for a given access size.
    function automatic logic [1:0] last_idx(input size_t s);
        case (s)
            HALF:    return 2'd1;
            WORD:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_load_extend.sv
// Sign or zero extension of an assembled load value to 32 bits.
module load_extend
    import mem_seq_pkg::*;
(
    input  size_t       i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    logic w_sb;
    logic w_sh;

    assign w_sb = ~i_unsigned & i_raw[7];
    assign w_sh = ~i_unsigned & i_raw[15];

    always_comb begin
        o_data = i_raw;
        case (i_size)
            BYTE:    o_data = {{24{w_sb}}, i_raw[7:0]};
            HALF:    o_data = {{16{w_sh}}, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// Sequences 8/16/32-bit loads and stores onto a byte-wide RAM,
// big-endian, one byte per cycle, with a four-phase MOV/MOC handshake.
module mem_byte_sequencer
    import mem_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [5:0]  OpC,
    input  logic [8:0]  MAR,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        MOC,
    output logic        AdE,
    output logic [8:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        mem_we
);

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_base;
    logic [31:0] r_data;
    logic [31:0] r_acc;
    logic [31:0] r_dout;
    size_t       r_size;
    logic        r_uns;
    logic        r_rd;
    logic        r_ade;
    logic [1:0]  r_cnt;

    op_info_t    w_op;
    logic        w_mis;
    logic        w_err;
    logic [1:0]  w_last_cnt;
    logic        w_last;
    logic [1:0]  w_shift;
    logic [31:0] w_acc_next;
    logic [31:0] w_ext;
    logic        w_access;

    assign w_op  = decode_op(OpC);
    assign w_mis = ((w_op.size == HALF) && MAR[0])
                 || ((w_op.size == WORD) && (MAR[1:0] != 2'b00));
    assign w_err = !w_op.valid || (RW != w_op.load) || w_mis;

    assign w_last_cnt = last_idx(r_size);
    assign w_last     = (r_cnt == w_last_cnt);
    assign w_shift    = w_last_cnt - r_cnt;
    assign w_acc_next = {r_acc[23:0], mem_rdata};
    assign w_access   = (r_state == ACCESS);

    load_extend u_ext (
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .i_raw      (w_acc_next),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (MOV) w_next = w_err ? DONE : ACCESS;
            ACCESS:  if (w_last) w_next = DONE;
            DONE:    if (!MOV) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base <= '0;
            r_data <= '0;
            r_acc  <= '0;
            r_dout <= '0;
            r_size <= BYTE;
            r_uns  <= 1'b0;
            r_rd   <= 1'b0;
            r_ade  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (MOV) begin
                        r_base <= MAR;
                        r_data <= DataIn;
                        r_size <= w_op.size;
                        r_uns  <= w_op.uns;
                        r_rd   <= RW;
                        r_ade  <= w_err;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ACCESS: begin
                    if (r_rd) r_acc <= w_acc_next;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_rd) r_dout <= w_ext;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                DONE: if (!MOV) r_ade <= 1'b0;
                default: r_cnt <= '0;
            endcase
        end
    end

    // Write strobe is gated by reset so an abort never lands a byte.
    assign mem_we    = w_access && !r_rd && !reset;
    assign mem_addr  = w_access ? (r_base + {7'd0, r_cnt}) : r_base;
    assign mem_wdata = (w_access && !r_rd)
                     ? r_data[{w_shift, 3'b000} +: 8] : 8'h00;
    assign MOC       = (r_state == DONE);
    assign AdE       = r_ade;
    assign DataOut   = r_dout;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed scoreboard bench for mem_byte_sequencer against a 512x8
// byte RAM model.
module tb_mem_byte_sequencer;

    logic        clk;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [5:0]  OpC;
    logic [8:0]  MAR;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MOC;
    logic        AdE;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_we;

    logic [7:0]  mem [0:511];

    typedef struct {
        logic [31:0] dout;
        logic        ade;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [8:0]  addr_q[$];
    int          n_cmp;
    int          n_err;
    int          we_cnt;
    logic [31:0] m_dout;

    mem_byte_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .MOV       (MOV),
        .RW        (RW),
        .OpC       (OpC),
        .MAR       (MAR),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .MOC       (MOC),
        .AdE       (AdE),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    always @(negedge clk) if (mem_we) we_cnt++;

    // Drive one request and wait (bounded) for MOC; MOV stays high.
    task automatic issue(input logic [5:0] opc, input logic rw,
                         input logic [8:0] mar, input logic [31:0] din,
                         output int lat);
        @(negedge clk);
        OpC = opc; RW = rw; MAR = mar; DataIn = din; MOV = 1'b1;
        addr_q.delete();
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!MOC) addr_q.push_back(mem_addr);
            if (lat == 1) begin
                MAR = ~mar; DataIn = ~din; OpC = 6'b111111; RW = ~rw;
            end
        end while (!MOC && lat < 40);
        if (!MOC) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: MOC=%b after %0d cycles, want 1",
                     MOC, lat);
        end
    endtask

    task automatic drop();
        @(negedge clk); MOV = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; MOV = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (MOC !== 1'b0) begin n_err++;
            $display("FAIL rst_moc: got %b want 0", MOC); end
        if (AdE !== 1'b0) begin n_err++;
            $display("FAIL rst_ade: got %b want 0", AdE); end
        if (DataOut !== 32'h0) begin n_err++;
            $display("FAIL rst_dout: got %h want 0", DataOut); end
        if (mem_we !== 1'b0) begin n_err++;
            $display("FAIL rst_we: got %b want 0", mem_we); end
        if (mem_addr !== 9'h0) begin n_err++;
            $display("FAIL rst_addr: got %h want 0", mem_addr); end
        if (mem_wdata !== 8'h0) begin n_err++;
            $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        @(negedge clk); reset = 1'b0;
        m_dout = 32'h0;
    endtask

    task automatic test_loads();
        logic [5:0]  opc [3] = '{6'b100011, 6'b100000, 6'b100100};
        logic [8:0]  adr [3] = '{9'h004, 9'h009, 9'h009};
        logic [31:0] val [3] = '{32'h12345678, 32'hFFFFFF80,
                                 32'h00000080};
        int          lt  [3] = '{5, 2, 2};
        int lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{val[i], 1'b0, lt[i]});
            m_dout = val[i];
            issue(opc[i], 1'b1, adr[i], 32'h0, lat);
            e = exp_q.pop_front();
            n_cmp += 3;
            if (DataOut !== e.dout) begin n_err++;
                $display("FAIL load%0d_dout: got %h want %h",
                         i, DataOut, e.dout); end
            if (AdE !== e.ade) begin n_err++;
                $display("FAIL load%0d_ade: got %b want %b",
                         i, AdE, e.ade); end
            if (lat != e.lat) begin n_err++;
                $display("FAIL load%0d_lat: got %0d want %0d",
                         i, lat, e.lat); end
            if (i == 0) begin
                n_cmp++;
                if (addr_q.size() != 4) begin n_err++;
                    $display("FAIL lw_naddr: got %0d want 4",
                             addr_q.size()); end
            end
            drop();
        end
    endtask

    task automatic test_store_half();
        logic [7:0] m9, m12;
        int w0, lat;
        exp_t e;
        logic [5:0]  opc [3] = '{6'b101001, 6'b100001, 6'b100101};
        logic        rw  [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] val [3] = '{32'h0, 32'hFFFFBEEF, 32'h0000BEEF};
        m9 = mem[9]; m12 = mem[12]; w0 = we_cnt;
        for (int i = 0; i < 3; i++) begin
            if (rw[i]) m_dout = val[i];
            exp_q.push_back('{m_dout, 1'b0, 3});
            issue(opc[i], rw[i], 9'h00A, 32'hDEADBEEF, lat);
            e = exp_q.pop_front();
            n_cmp += 2;
            if (DataOut !== e.dout) begin n_err++;
                $display("FAIL half%0d_dout: got %h want %h",
                         i, DataOut, e.dout); end
            if (lat != e.lat) begin n_err++;
                $display("FAIL half%0d_lat: got %0d want %0d",
                         i, lat, e.lat); end
            drop();
            if (i == 0) begin
                n_cmp += 5;
                if (mem[10] !== 8'hBE) begin n_err++;
                    $display("FAIL sh_m10: got %h want be", mem[10]); end
                if (mem[11] !== 8'hEF) begin n_err++;
                    $display("FAIL sh_m11: got %h want ef", mem[11]); end
                if (mem[9] !== m9) begin n_err++;
                    $display("FAIL sh_m9: got %h want %h", mem[9], m9); end
                if (mem[12] !== m12) begin n_err++;
                    $display("FAIL sh_m12: got %h want %h",
                             mem[12], m12); end
                if (we_cnt - w0 != 2) begin n_err++;
                    $display("FAIL sh_we: got %0d want 2",
                             we_cnt - w0); end
            end
        end
    endtask

    task automatic test_errors();
        logic [5:0] opc [3] = '{6'b100011, 6'b000000, 6'b100011};
        logic       rw  [3] = '{1'b1, 1'b1, 1'b0};
        logic [8:0] adr [3] = '{9'h006, 9'h008, 9'h008};
        int w0, lat;
        exp_t e;
        w0 = we_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{m_dout, 1'b1, 1});
            issue(opc[i], rw[i], adr[i], 32'h01020304, lat);
            e = exp_q.pop_front();
            n_cmp += 3;
            if (DataOut !== e.dout) begin n_err++;
                $display("FAIL err%0d_dout: got %h want %h",
                         i, DataOut, e.dout); end
            if (AdE !== e.ade) begin n_err++;
                $display("FAIL err%0d_ade: got %b want %b",
                         i, AdE, e.ade); end
            if (lat != e.lat) begin n_err++;
                $display("FAIL err%0d_lat: got %0d want %0d",
                         i, lat, e.lat); end
            drop();
        end
        n_cmp++;
        if (we_cnt != w0) begin n_err++;
            $display("FAIL err_we: got %0d writes want 0", we_cnt - w0);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] m17, m18, m19;
        int w0;
        m17 = mem[17]; m18 = mem[18]; m19 = mem[19]; w0 = we_cnt;
        @(negedge clk);
        OpC = 6'b101011; RW = 1'b0; MAR = 9'h010;
        DataIn = 32'hAABBCCDD; MOV = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_cmp += 3;
        if (MOC !== 1'b0) begin n_err++;
            $display("FAIL abort_moc: got %b want 0", MOC); end
        if (DataOut !== 32'h0) begin n_err++;
            $display("FAIL abort_dout: got %h want 0", DataOut); end
        if (mem_addr !== 9'h0) begin n_err++;
            $display("FAIL abort_addr: got %h want 0", mem_addr); end
        @(negedge clk); reset = 1'b0; MOV = 1'b0;
        m_dout = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 6;
        if (MOC !== 1'b0) begin n_err++;
            $display("FAIL abort_moc2: got %b want 0", MOC); end
        if (mem[16] !== 8'hAA) begin n_err++;
            $display("FAIL abort_m16: got %h want aa", mem[16]); end
        if (mem[17] !== m17) begin n_err++;
            $display("FAIL abort_m17: got %h want %h", mem[17], m17); end
        if (mem[18] !== m18) begin n_err++;
            $display("FAIL abort_m18: got %h want %h", mem[18], m18); end
        if (mem[19] !== m19) begin n_err++;
            $display("FAIL abort_m19: got %h want %h", mem[19], m19); end
        if (we_cnt - w0 != 1) begin n_err++;
            $display("FAIL abort_we: got %0d want 1", we_cnt - w0); end
    endtask

    task automatic test_back_to_back();
        int w0, lat;
        exp_t e;
        exp_q.push_back('{32'h12345678, 1'b0, 5});
        issue(6'b100011, 1'b1, 9'h004, 32'h0, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (DataOut !== e.dout) begin n_err++;
            $display("FAIL hold_dout: got %h want %h", DataOut, e.dout);
        end
        w0 = we_cnt;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp += 2;
            if (MOC !== 1'b1) begin n_err++;
                $display("FAIL hold%0d_moc: got %b want 1", i, MOC); end
            if (mem_addr !== 9'h004) begin n_err++;
                $display("FAIL hold%0d_addr: got %h want 004",
                         i, mem_addr); end
        end
        drop();
        n_cmp += 2;
        if (MOC !== 1'b0) begin n_err++;
            $display("FAIL hold_release: got %b want 0", MOC); end
        if (we_cnt != w0) begin n_err++;
            $display("FAIL hold_we: got %0d want 0", we_cnt - w0); end
        exp_q.push_back('{32'hCAFEBABE, 1'b0, 5});
        issue(6'b100011, 1'b1, 9'h1FC, 32'h0, lat);
        e = exp_q.pop_front();
        n_cmp += 4;
        if (DataOut !== e.dout) begin n_err++;
            $display("FAIL top_dout: got %h want %h", DataOut, e.dout); end
        if (AdE !== e.ade) begin n_err++;
            $display("FAIL top_ade: got %b want %b", AdE, e.ade); end
        if (lat != e.lat) begin n_err++;
            $display("FAIL top_lat: got %0d want %0d", lat, e.lat); end
        if (addr_q.size() != 4) begin n_err++;
            $display("FAIL top_naddr: got %0d want 4", addr_q.size()); end
        for (int i = 0; i < addr_q.size() && i < 4; i++) begin
            n_cmp++;
            if (addr_q[i] !== 9'(9'h1FC + i)) begin n_err++;
                $display("FAIL top_addr%0d: got %h want %h",
                         i, addr_q[i], 9'(9'h1FC + i)); end
        end
        drop();
    endtask

    initial begin
        n_cmp = 0; n_err = 0; we_cnt = 0; m_dout = 32'h0;
        reset = 1'b1; MOV = 1'b0; RW = 1'b0;
        OpC = 6'h0; MAR = 9'h0; DataIn = 32'h0;
        for (int i = 0; i < 512; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'h56; mem[7] = 8'h78;
        mem[9] = 8'h80;
        mem[9'h1FC] = 8'hCA; mem[9'h1FD] = 8'hFE;
        mem[9'h1FE] = 8'hBA; mem[9'h1FF] = 8'hBE;
        test_reset();
        test_loads();
        test_store_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_byte_sequencer.md
MEM_BYTE_SEQUENCER -- requirements
Module: mem_byte_sequencer

Interface
REQ-001 SHALL have a single clock `clk` and a synchronous, active-high reset `reset`.
REQ-002 SHALL have the following ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- MOV  in  1  memory operation valid, from datapath; held high until MOC is seen
- RW  in  1  1 = read (load), 0 = write (store)
- OpC  in  6  MIPS opcode: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011
- MAR  in  9  byte address
- DataIn  in  32  store data; the low 8, 16 or 32 bits are used
- DataOut  out  32  load result, sign- or zero-extended
- MOC  out  1  memory operation complete
- AdE  out  1  alignment/opcode error, valid while MOC=1
- mem_addr  out  9  byte RAM address
- mem_wdata  out  8  byte to write
- mem_rdata  in  8  byte read; combinational from mem_addr
- mem_we  out  1  byte write enable, sampled by the RAM on the rising edge of clk

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-004 In IDLE, when MOV=1: latch MAR, OpC, RW and DataIn; set N = 1 (byte), 2 (half) or 4 (word); clear the byte counter; go to ACCESS.
REQ-005 In IDLE, if the op is misaligned (half with MAR[0]=1; word with MAR[1:0]!=0), or OpC is not one of the listed opcodes, or RW disagrees with OpC class, go directly to DONE with AdE=1 and perform no RAM access.
REQ-006 In ACCESS, transfer one byte per cycle at mem_addr = base + cnt (9-bit arithmetic). Ordering is big-endian: cnt 0 is the MSB of the item.
REQ-007 On a read in ACCESS, shift mem_rdata into the accumulator at the clock edge; mem_we=0.
REQ-008 On a write in ACCESS, mem_wdata = byte (N-1-cnt) of DataIn[8N-1:0] and mem_we=1.
REQ-009 After the byte with cnt = N-1, go to DONE.
REQ-010 Latency from MOV sampled to MOC=1 SHALL be N+1 cycles, or 1 cycle on an error.
REQ-011 In DONE, MOC=1 and mem_we=0; the FSM stays in DONE while MOV=1 and goes to IDLE on the first cycle with MOV=0 (four-phase handshake).
REQ-012 DataOut SHALL be updated on entry to DONE for reads only and hold its value until the next read completes.
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- Error: DataOut unchanged.
REQ-013 Changes on MAR, OpC, RW or DataIn after latching SHALL be ignored until the FSM returns to IDLE.
REQ-014 mem_we SHALL be 0 in IDLE and DONE; mem_addr SHALL equal the latched base address outside ACCESS.
REQ-015 MOV=1 arriving in DONE after a deassertion SHALL be accepted only once the FSM is in IDLE; no request is lost or doubled.

Reset
REQ-016 Reset SHALL force state IDLE, MOC=0, AdE=0, DataOut=0, mem_we=0, mem_addr=0, mem_wdata=0, and cnt=0 at the next edge.
REQ-017 Reset during ACCESS SHALL abort the operation.
- Bytes already written stay written; no rollback.
- No MOC is produced for the aborted request.
REQ-018 Reset has priority over MOV in the same cycle.

Structure
REQ-019 Package mem_seq_pkg SHALL hold the opcode constants, the state encoding and the size encodings (BYTE, HALF, WORD).
REQ-020 Sign/zero extension SHALL be a sub-module `load_extend` (size, unsigned flag, 32-bit raw value -> 32-bit result).
REQ-021 The RTL SHALL be synthesizable with no latches; the FSM is a registered state plus combinational next-state logic.

Verification
REQ-022 The bench SHALL connect the block to ram512x8-style byte memory preloaded from a file, and cover these directed scenarios:
- LW at 0x004, Mem[4..7] = 12 34 56 78 -> MOC at cycle 5; DataOut = 0x12345678; AdE = 0.
- LB at 0x009, Mem[9] = 0x80 -> DataOut = 0xFFFFFF80; the same address with LBU -> 0x00000080; MOC at cycle 2.
- SH at 0x00A, DataIn = 0xDEADBEEF -> Mem[10] = 0xBE, Mem[11] = 0xEF; Mem[9] and Mem[12] unchanged; mem_we high exactly 2 cycles.
- LW at 0x006 (misaligned) -> MOC at cycle 1; AdE = 1; no mem_we; DataOut unchanged.
- Reset asserted in the 2nd ACCESS cycle of SW at 0x010 with DataIn = 0xAABBCCDD -> Mem[16] = 0xAA written, Mem[17..19] untouched; state IDLE; MOC = 0.
- MOV held high for 3 cycles after MOC -> MOC stays 1 and no second access occurs; after MOV drops, a new LW at 0x1FC completes normally, with addresses 0x1FC..0x1FF.
